servo_dac_writer: RTL and testbench
===================================

Name: servo_dac_writer

Overview:
- Output stage of the servo loop: takes the 32-bit saturating accumulator result (s, overflow, underflow) on an update strobe.
- Derives a 16-bit DAC code from it and clamps the code to software limits.
- Serialises the code as a 24-bit SPI-style write frame (8-bit command + 16-bit code) to the loop's output DAC.
- Sits between the multiply-accumulate integrator and the DAC pins; this is the transmit end of that integrator's result interface.

Parameters:
DIV, 2, clk cycles per sclk half-period (>=1)
CMD_BITS, 8, width of command prefix
DATA_BITS, 16, width of DAC code

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
s  input  32  accumulator value; DAC code source is s[31:16] (unsigned)
overflow  input  1  accumulator above range
underflow  input  1  accumulator below range (takes priority over overflow)
update  input  1  one-cycle strobe: sample s/overflow/underflow
upper_limit  input  16  max allowed DAC code
lower_limit  input  16  min allowed DAC code
cmd  input  8  command prefix, sampled together with s
sclk  output  1  serial clock, idle low
sdi  output  1  serial data, MSB first
cs_n  output  1  frame select, active low
busy  output  1  frame in progress or pending
done  output  1  one-cycle pulse when cs_n returns high
dac_code  output  16  last code committed to a frame
limited  output  1  last committed code was clamped or saturated

Behaviour:
- Reset (async, rst_n low): sclk=0, sdi=0, cs_n=1, busy=0, done=0, dac_code=0, limited=0. FSM goes to IDLE; pending flag and shift register are cleared. Reset mid-frame aborts the frame immediately; no done pulse.
- Code derivation, registered on the cycle after update:
  - raw = 0x0000 if underflow; else 0xFFFF if overflow; else s[31:16].
  - Clamp upper first: if raw > upper_limit then upper_limit.
  - Then clamp lower: if result < lower_limit then lower_limit. Lower wins when lower_limit > upper_limit.
  - limited = underflow | overflow | (final != s[31:16]).
  - The result goes into the pending register and sets pending=1.
- Update while busy: the pending register is overwritten with the newest sample (latest wins). The frame currently shifting is never altered.
- FSM states and transitions:
  - IDLE: if pending, load shift register {cmd, code}, latch dac_code/limited, clear pending, cs_n=0, go to LEAD.
  - LEAD: hold DIV cycles with sclk=0; sdi carries the frame MSB.
  - SHIFT: 24 bits. Each bit is 2*DIV cycles: sclk low for DIV, then high for DIV. sdi changes only at the sclk falling edge / start of a bit, so it is stable across the rising edge.
  - TRAIL: after the last sclk fall, hold cs_n=0 for DIV cycles; then cs_n=1 and done=1 for one cycle.
  - GAP: cs_n high for 2*DIV cycles; then LEAD if pending (load as in IDLE), else IDLE.
- Latency:
  - update at cycle 0 → code registered at cycle 1 → cs_n falls at cycle 2.
  - With DIV=2, cs_n is low for 2+96+2 = 100 cycles.
  - Minimum frame-to-frame spacing is 104 cycles.
- busy = (state != IDLE) | pending.
- update in the same cycle as GAP exit: the new sample is written to pending that cycle. It is picked up on the following IDLE check (1 cycle later); no sample is lost.
- update and rst_n low together: reset wins.
- All outputs are registered; no combinational path from inputs to sclk/sdi/cs_n.

Test Plan:
1. Reset mid-frame: assert rst_n=0 at bit 10 → cs_n=1, sclk=0, sdi=0, busy=0, no done pulse; next update produces a full clean frame.
2. Nominal: s=0x8000_1234, flags 0, limits 0x0000/0xFFFF, cmd=0x30 → cs_n falls 2 cycles after update; 24 sampled bits = 0x308000; dac_code=0x8000, limited=0; done pulses 100 cycles after the cs_n fall.
3. Saturation: overflow=1, upper_limit=0xF000 → code 0xF000, limited=1. Then underflow=1 with overflow=1, lower_limit=0x0100 → code 0x0100, limited=1.
4. Clamping: s[31:16]=0x0050 with lower_limit=0x0100 → code 0x0100. Then lower_limit=0x9000, upper_limit=0x8000 with s[31:16]=0x8800 → code 0x9000 (lower wins).
5. Back-to-back: updates with codes 0x1111, 0x2222, 0x3333 at cycles 0, 20, 40 → exactly two frames (0x1111, then 0x3333); second cs_n fall ≥104 cycles after the first; busy stays high throughout.
6. DIV=1 parameter run: nominal frame has sclk period 2 cycles; cs_n low for 1+48+1 = 50 cycles; data identical to test 2.

Source files
------------

// File: rtl/servo_dac_writer.sv
// ---------------------------------------------------------------------------
// servo_dac_writer
//
// Output stage of the servo loop. It samples the saturating accumulator result
// whenever update strobes, turns it into a 16-bit DAC code, and clamps that
// code to the software limits. It then shifts {cmd, code} out MSB first as an
// SPI-style write frame to the loop's output DAC.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   s            accumulator value; the DAC code source is s[31:16] (unsigned)
//   overflow     accumulator above range
//   underflow    accumulator below range (takes priority over overflow)
//   update       one-cycle strobe: sample s / overflow / underflow / cmd
//   upper_limit  maximum allowed DAC code
//   lower_limit  minimum allowed DAC code (wins over upper_limit)
//   cmd          command prefix of the frame
//   sclk         serial clock, idle low
//   sdi          serial data, MSB first, changes only while sclk is low
//   cs_n         frame select, active low
//   busy         frame in progress or a sample is pending
//   done         one-cycle pulse when cs_n returns high
//   dac_code     last code committed to a frame
//   limited      last committed code was clamped or saturated
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no frame; a pending sample starts one
// LEAD  | cs_n low, sclk low for DIV cycles, sdi already carries the MSB
// SHIFT | FRAME bits, each DIV cycles low then DIV cycles high
// TRAIL | cs_n held low for DIV cycles after the last sclk fall
// GAP   | cs_n high for 2*DIV cycles (first cycle carries done)
// ---------------------------------------------------------------------------
module servo_dac_writer #(
    parameter int DIV       = 2,
    parameter int CMD_BITS  = 8,
    parameter int DATA_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          s,
    input  logic                 overflow,
    input  logic                 underflow,
    input  logic                 update,
    input  logic [DATA_BITS-1:0] upper_limit,
    input  logic [DATA_BITS-1:0] lower_limit,
    input  logic [CMD_BITS-1:0]  cmd,
    output logic                 sclk,
    output logic                 sdi,
    output logic                 cs_n,
    output logic                 busy,
    output logic                 done,
    output logic [DATA_BITS-1:0] dac_code,
    output logic                 limited
);

    localparam int FRAME = CMD_BITS + DATA_BITS;
    localparam int TW    = $clog2(2 * DIV + 1);
    localparam int BW    = $clog2(FRAME);

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SHIFT,
        TRAIL,
        GAP
    } state_t;

    state_t               state;
    logic [TW-1:0]        tmr;
    logic [BW-1:0]        bit_cnt;
    logic                 phase;      // 0: sclk low half of a bit, 1: high half
    logic [FRAME-1:0]     shreg;

    logic                 pending;
    logic [DATA_BITS-1:0] pend_code;
    logic                 pend_lim;
    logic [CMD_BITS-1:0]  pend_cmd;

    logic [DATA_BITS-1:0] src;
    logic [DATA_BITS-1:0] raw;
    logic [DATA_BITS-1:0] clamped;
    logic [DATA_BITS-1:0] code_next;
    logic                 lim_next;
    logic [FRAME-1:0]     frame_next;
    logic                 unused_low_bits;

    // Only the top half of the accumulator drives the DAC.
    assign src             = s[31 -: DATA_BITS];
    assign unused_low_bits = ^s[31-DATA_BITS:0];
    assign frame_next      = {pend_cmd, pend_code};

    // Saturation first, then upper clamp, then lower clamp so that an
    // inverted limit pair resolves to lower_limit.
    always_comb begin
        raw = src;
        if (underflow) begin
            raw = '0;
        end else if (overflow) begin
            raw = '1;
        end
        clamped   = (raw > upper_limit) ? upper_limit : raw;
        code_next = (clamped < lower_limit) ? lower_limit : clamped;
        lim_next  = underflow | overflow | (code_next != src);
    end

    assign busy = (state != IDLE) | pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tmr       <= '0;
            bit_cnt   <= '0;
            phase     <= 1'b0;
            shreg     <= '0;
            pending   <= 1'b0;
            pend_code <= '0;
            pend_lim  <= 1'b0;
            pend_cmd  <= '0;
            sclk      <= 1'b0;
            sdi       <= 1'b0;
            cs_n      <= 1'b1;
            done      <= 1'b0;
            dac_code  <= '0;
            limited   <= 1'b0;
        end else begin
            done <= 1'b0;

            case (state)
                IDLE: begin
                    if (pending) begin
                        shreg    <= frame_next;
                        sdi      <= frame_next[FRAME-1];
                        sclk     <= 1'b0;
                        cs_n     <= 1'b0;
                        dac_code <= pend_code;
                        limited  <= pend_lim;
                        pending  <= 1'b0;
                        tmr      <= TW'(DIV - 1);
                        state    <= LEAD;
                    end
                end

                LEAD: begin
                    if (tmr == '0) begin
                        tmr     <= TW'(DIV - 1);
                        phase   <= 1'b0;
                        bit_cnt <= BW'(FRAME - 1);
                        state   <= SHIFT;
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end

                SHIFT: begin
                    if (tmr != '0) begin
                        tmr <= tmr - TW'(1);
                    end else if (!phase) begin
                        sclk  <= 1'b1;
                        phase <= 1'b1;
                        tmr   <= TW'(DIV - 1);
                    end else begin
                        // Falling edge: the next bit is presented here so it
                        // has a full low half-period before the next rise.
                        sclk  <= 1'b0;
                        phase <= 1'b0;
                        tmr   <= TW'(DIV - 1);
                        if (bit_cnt == '0) begin
                            state <= TRAIL;
                        end else begin
                            bit_cnt <= bit_cnt - BW'(1);
                            shreg   <= shreg << 1;
                            sdi     <= shreg[FRAME-2];
                        end
                    end
                end

                TRAIL: begin
                    if (tmr == '0) begin
                        cs_n  <= 1'b1;
                        sdi   <= 1'b0;
                        done  <= 1'b1;
                        tmr   <= TW'(2 * DIV - 1);
                        state <= GAP;
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end

                GAP: begin
                    if (tmr != '0) begin
                        tmr <= tmr - TW'(1);
                    end else if (pending) begin
                        shreg    <= frame_next;
                        sdi      <= frame_next[FRAME-1];
                        sclk     <= 1'b0;
                        cs_n     <= 1'b0;
                        dac_code <= pend_code;
                        limited  <= pend_lim;
                        pending  <= 1'b0;
                        tmr      <= TW'(DIV - 1);
                        state    <= LEAD;
                    end else begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase

            // A new sample always lands in the pending slot, even on the
            // cycle the previous one is being loaded (latest wins).
            if (update) begin
                pending   <= 1'b1;
                pend_code <= code_next;
                pend_lim  <= lim_next;
                pend_cmd  <= cmd;
            end
        end
    end

endmodule

// File: tb/tb_servo_dac_writer.sv
module tb_servo_dac_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] s;
    logic        overflow, underflow;
    logic        update0, update1;
    logic [15:0] upper_limit, lower_limit;
    logic [7:0]  cmd;

    logic [1:0]  sclk_v, sdi_v, cs_v, busy_v, done_v, lim_v;
    logic [15:0] dac_code0, dac_code1;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    servo_dac_writer #(.DIV(2)) u0 (
        .clk(clk), .rst_n(rst_n), .s(s), .overflow(overflow), .underflow(underflow),
        .update(update0), .upper_limit(upper_limit), .lower_limit(lower_limit), .cmd(cmd),
        .sclk(sclk_v[0]), .sdi(sdi_v[0]), .cs_n(cs_v[0]), .busy(busy_v[0]),
        .done(done_v[0]), .dac_code(dac_code0), .limited(lim_v[0])
    );

    servo_dac_writer #(.DIV(1)) u1 (
        .clk(clk), .rst_n(rst_n), .s(s), .overflow(overflow), .underflow(underflow),
        .update(update1), .upper_limit(upper_limit), .lower_limit(lower_limit), .cmd(cmd),
        .sclk(sclk_v[1]), .sdi(sdi_v[1]), .cs_n(cs_v[1]), .busy(busy_v[1]),
        .done(done_v[1]), .dac_code(dac_code1), .limited(lim_v[1])
    );

    typedef struct {
        logic [23:0] data;
        int          bits;
        int          fall;
        int          low_len;
        logic        done_at_rise;
        int          minp;
        int          maxp;
    } frame_t;

    frame_t fq0[$];
    frame_t fq1[$];

    int checks = 0;
    int errors = 0;
    int upd_cyc;

    // Bus monitor: reconstructs frames from the pins, sampled at negedge.
    logic [1:0]  pcs = 2'b11;
    logic [1:0]  psclk = 2'b00;
    logic [23:0] mdata [2];
    int          mbits [2];
    int          mfall [2];
    int          lastrise [2];
    int          minp [2];
    int          maxp [2];
    int          done_cnt [2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            mdata[k] = '0; mbits[k] = 0; mfall[k] = 0; lastrise[k] = -1;
            minp[k] = 1000; maxp[k] = 0; done_cnt[k] = 0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                frame_t f;
                if (done_v[k]) done_cnt[k]++;
                if (!rst_n) begin
                    pcs[k] = 1'b1;
                    psclk[k] = 1'b0;
                    mbits[k] = 0;
                end else begin
                    if (pcs[k] && !cs_v[k]) begin
                        mfall[k] = cyc; mbits[k] = 0; mdata[k] = '0;
                        lastrise[k] = -1; minp[k] = 1000; maxp[k] = 0;
                    end
                    if (!cs_v[k] && !psclk[k] && sclk_v[k]) begin
                        mdata[k] = {mdata[k][22:0], sdi_v[k]};
                        mbits[k]++;
                        if (lastrise[k] >= 0) begin
                            if (cyc - lastrise[k] < minp[k]) minp[k] = cyc - lastrise[k];
                            if (cyc - lastrise[k] > maxp[k]) maxp[k] = cyc - lastrise[k];
                        end
                        lastrise[k] = cyc;
                    end
                    if (!pcs[k] && cs_v[k]) begin
                        f.data = mdata[k]; f.bits = mbits[k]; f.fall = mfall[k];
                        f.low_len = cyc - mfall[k]; f.done_at_rise = done_v[k];
                        f.minp = minp[k]; f.maxp = maxp[k];
                        if (k == 0) fq0.push_back(f); else fq1.push_back(f);
                    end
                    pcs[k] = cs_v[k];
                    psclk[k] = sclk_v[k];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: saturate, clamp to upper, then to lower (lower wins).
    function automatic logic [16:0] model(input logic [31:0] sv, input bit ov, input bit un,
                                          input int up, input int lo);
        int  src, raw, c;
        bit  lim;
        src = int'(sv >> 16);
        raw = un ? 0 : (ov ? 65535 : src);
        c   = (raw > up) ? up : raw;
        c   = (c < lo) ? lo : c;
        lim = un || ov || (c != src);
        return {lim, c[15:0]};
    endfunction

    task automatic pulse(input bit which, input logic [31:0] sv, input bit ov, input bit un,
                         input logic [15:0] up, input logic [15:0] lo, input logic [7:0] c);
        @(negedge clk);
        s = sv; overflow = ov; underflow = un;
        upper_limit = up; lower_limit = lo; cmd = c;
        if (which) update1 = 1'b1; else update0 = 1'b1;
        upd_cyc = cyc;
        @(negedge clk);
        update0 = 1'b0;
        update1 = 1'b0;
    endtask

    task automatic expect_frame0(input string tag, input logic [23:0] exp_data,
                                 input logic [15:0] exp_code, input logic exp_lim);
        frame_t f;
        for (int i = 0; i < 400 && fq0.size() == 0; i++) @(negedge clk);
        check({tag, "_arrived"}, fq0.size() > 0, 1);
        if (fq0.size() > 0) begin
            f = fq0.pop_front();
            check({tag, "_data"}, f.data, exp_data);
            check({tag, "_bits"}, f.bits, 24);
            check({tag, "_cs_low"}, f.low_len, 100);
            check({tag, "_latency"}, f.fall - upd_cyc, 2);
            check({tag, "_done"}, f.done_at_rise, 1);
            check({tag, "_code"}, dac_code0, exp_code);
            check({tag, "_limited"}, lim_v[0], exp_lim);
        end
        repeat (6) @(negedge clk);
        check({tag, "_idle"}, busy_v[0], 0);
    endtask

    logic [15:0] b2b [3];
    int          t0, busy_drop, nd;
    logic [31:0] rs;
    logic [15:0] rup, rlo;
    logic [7:0]  rc;
    bit          rov, run;
    logic [16:0] m;
    frame_t      g;

    initial begin
        rst_n = 1'b0; update0 = 1'b0; update1 = 1'b0; s = '0;
        overflow = 1'b0; underflow = 1'b0;
        upper_limit = 16'hFFFF; lower_limit = 16'h0000; cmd = 8'h00;
        b2b[0] = 16'h1111; b2b[1] = 16'h2222; b2b[2] = 16'h3333;

        repeat (3) @(negedge clk);
        check("rst_cs_n", cs_v[0], 1);
        check("rst_sclk", sclk_v[0], 0);
        check("rst_sdi", sdi_v[0], 0);
        check("rst_busy", busy_v[0], 0);
        check("rst_done", done_v[0], 0);
        check("rst_code", dac_code0, 16'h0000);
        check("rst_limited", lim_v[0], 0);
        check("rst_cs_n_div1", cs_v[1], 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Reset in the middle of a frame
        pulse(0, 32'h8000_1234, 0, 0, 16'hFFFF, 16'h0000, 8'h30);
        for (int i = 0; i < 400 && mbits[0] < 10; i++) @(negedge clk);
        check("midrst_reached_bit10", mbits[0] >= 10, 1);
        nd = done_cnt[0];
        rst_n = 1'b0;
        #1;
        check("midrst_cs_n", cs_v[0], 1);
        check("midrst_sclk", sclk_v[0], 0);
        check("midrst_sdi", sdi_v[0], 0);
        check("midrst_busy", busy_v[0], 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("midrst_no_done", done_cnt[0], nd);
        check("midrst_no_frame", fq0.size(), 0);

        // Nominal frame
        pulse(0, 32'h8000_1234, 0, 0, 16'hFFFF, 16'h0000, 8'h30);
        expect_frame0("nominal", 24'h308000, 16'h8000, 0);

        // Saturation
        pulse(0, 32'h1234_5678, 1, 0, 16'hF000, 16'h0000, 8'h30);
        expect_frame0("sat_over", 24'h30F000, 16'hF000, 1);
        pulse(0, 32'h1234_5678, 1, 1, 16'hF000, 16'h0100, 8'h30);
        expect_frame0("sat_under", 24'h300100, 16'h0100, 1);

        // Clamping
        pulse(0, 32'h0050_ABCD, 0, 0, 16'hFFFF, 16'h0100, 8'h30);
        expect_frame0("clamp_low", 24'h300100, 16'h0100, 1);
        pulse(0, 32'h8800_0000, 0, 0, 16'h8000, 16'h9000, 8'h30);
        expect_frame0("clamp_inverted", 24'h309000, 16'h9000, 1);

        // Back-to-back updates at 0, 20, 40: latest pending wins
        upper_limit = 16'hFFFF; lower_limit = 16'h0000; cmd = 8'h30;
        overflow = 1'b0; underflow = 1'b0;
        busy_drop = 0; t0 = 0;
        @(negedge clk);
        for (int i = 0; i < 700; i++) begin
            if (i == 0 || i == 20 || i == 40) begin
                s = {b2b[i / 20], 16'h0000};
                update0 = 1'b1;
                if (i == 0) t0 = cyc;
            end else begin
                update0 = 1'b0;
            end
            if (i >= 1 && !busy_v[0]) busy_drop++;
            if (fq0.size() >= 2) break;
            @(negedge clk);
        end
        update0 = 1'b0;
        check("b2b_two_frames", fq0.size(), 2);
        check("b2b_busy_held", busy_drop, 0);
        if (fq0.size() >= 2) begin
            check("b2b_first_data", fq0[0].data, 24'h301111);
            check("b2b_second_data", fq0[1].data, 24'h303333);
            check("b2b_first_latency", fq0[0].fall - t0, 2);
            check("b2b_spacing", (fq0[1].fall - fq0[0].fall) >= 104, 1);
        end
        repeat (300) @(negedge clk);
        check("b2b_no_third", fq0.size(), 2);
        check("b2b_last_code", dac_code0, 16'h3333);
        fq0.delete();

        // DIV=1 instance
        pulse(1, 32'h8000_1234, 0, 0, 16'hFFFF, 16'h0000, 8'h30);
        for (int i = 0; i < 300 && fq1.size() == 0; i++) @(negedge clk);
        check("div1_arrived", fq1.size() > 0, 1);
        if (fq1.size() > 0) begin
            g = fq1.pop_front();
            check("div1_data", g.data, 24'h308000);
            check("div1_bits", g.bits, 24);
            check("div1_cs_low", g.low_len, 50);
            check("div1_latency", g.fall - upd_cyc, 2);
            check("div1_sclk_min_period", g.minp, 2);
            check("div1_sclk_max_period", g.maxp, 2);
            check("div1_done", g.done_at_rise, 1);
            check("div1_code", dac_code1, 16'h8000);
            check("div1_limited", lim_v[1], 0);
        end

        // Randomized samples against the reference model
        for (int n = 0; n < 10; n++) begin
            rs  = $urandom;
            rov = ($urandom_range(0, 3) == 0);
            run = ($urandom_range(0, 3) == 0);
            rc  = 8'($urandom);
            if (n % 2 == 0) begin
                rlo = 16'($urandom_range(0, 16'h7FFF));
                rup = 16'($urandom_range(16'h8000, 16'hFFFF));
            end else begin
                rlo = 16'($urandom);
                rup = 16'($urandom);
            end
            m = model(rs, rov, run, int'(rup), int'(rlo));
            pulse(0, rs, rov, run, rup, rlo, rc);
            expect_frame0($sformatf("rand%0d", n), {rc, m[15:0]}, m[15:0], m[16]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
